poly1305_msg_feeder: RTL



---
 rtl/poly1305_pkg.sv | 18 +
 rtl/poly1305_block_packer.sv | 46 ++++
 rtl/poly1305_msg_feeder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/poly1305_pkg.sv
// Shared types and constants for the Poly1305 message feeder and its block packer.
package poly1305_pkg;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [7:0] PAD_BYTE    = 8'h01;

  typedef logic [127:0] block_t;
  typedef logic [127:0] key_t;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    ISSUE,
    WAIT,
    TAG
  } feeder_state_e;

endpackage

// File: rtl/poly1305_block_packer.sv
// Little-endian byte buffer for one Poly1305 block. The padded view includes the
// byte being written this cycle, so the caller can register a finished block directly.
module poly1305_block_packer
  import poly1305_pkg::*;
(
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output block_t     m,
  output logic       fb,
  output logic       full
);

  logic [4:0] cnt_reg;
  logic [4:0] cnt_next;
  block_t     buf_reg;
  block_t     buf_next;

  assign cnt_next = cnt_reg + {4'd0, wr_en};
  assign fb       = (cnt_next == 5'(BLOCK_BYTES));
  assign full     = (cnt_reg == 5'(BLOCK_BYTES));

  // Byte gi is written when it is the next free slot; past the data it becomes
  // the 0x01 pad marker and then zeros. A full block passes through unchanged.
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
    assign buf_next[8*gi +: 8] = (wr_en && cnt_reg == 5'(gi)) ? wr_data : buf_reg[8*gi +: 8];
    assign m[8*gi +: 8] = (5'(gi) < cnt_next)  ? buf_next[8*gi +: 8] :
                          (5'(gi) == cnt_next) ? PAD_BYTE : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
      buf_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
      buf_reg <= '0;
    end else if (wr_en) begin
      cnt_reg <= cnt_next;
      buf_reg <= buf_next;
    end
  end

endmodule

// File: rtl/poly1305_msg_feeder.sv
// Feeds a byte-serial message to a Poly1305 block core as padded 16-byte blocks
// with a ld/rdy handshake, then presents the core's tag on a valid/ready port.
module poly1305_msg_feeder
  import poly1305_pkg::*;
#(
  parameter int BLOCK_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_r,
  input  logic [127:0] key_s,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic [127:0] core_r,
  output logic [127:0] core_s,
  output logic [127:0] core_m,
  output logic         core_fb,
  output logic         core_ld,
  output logic         core_first,
  input  logic [127:0] core_p,
  input  logic         core_rdy,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic [127:0] tag,
  output logic         busy
);

  if (BLOCK_BYTES != 16) begin : g_bad_block_bytes
    $error("poly1305_msg_feeder: BLOCK_BYTES must be 16");
  end

  feeder_state_e state_reg, state_next;
  key_t          core_r_reg, core_s_reg;
  block_t        core_m_reg;
  logic          core_fb_reg;
  logic          first_flag_reg;
  logic          last_flag_reg;
  logic          tag_valid_reg;
  block_t        tag_reg;

  block_t pk_m;
  logic   pk_fb;
  logic   pk_full;
  logic   pk_clr;
  logic   pk_wr;
  logic   block_done;

  assign pk_wr      = in_valid & in_ready;
  assign block_done = pk_wr & (pk_fb | in_last);

  poly1305_block_packer u_packer (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .clr     (pk_clr),
    .wr_en   (pk_wr),
    .wr_data (in_data),
    .m       (pk_m),
    .fb      (pk_fb),
    .full    (pk_full)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    key_ready  = 1'b0;
    in_ready   = 1'b0;
    core_ld    = 1'b0;
    pk_clr     = 1'b0;
    case (state_reg)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          pk_clr     = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        in_ready = ~pk_full;
        if (in_valid && !pk_full && (pk_fb || in_last)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        core_ld    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (core_rdy) begin
          if (last_flag_reg) begin
            state_next = TAG;
          end else begin
            pk_clr     = 1'b1;
            state_next = COLLECT;
          end
        end
      end
      TAG: begin
        if (tag_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Block, flags and tag registers; core_m/fb/first hold from ISSUE until rdy.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      core_r_reg     <= '0;
      core_s_reg     <= '0;
      core_m_reg     <= '0;
      core_fb_reg    <= 1'b0;
      first_flag_reg <= 1'b0;
      last_flag_reg  <= 1'b0;
      tag_valid_reg  <= 1'b0;
      tag_reg        <= '0;
    end else begin
      if (state_reg == IDLE && key_valid) begin
        core_r_reg     <= key_r;
        core_s_reg     <= key_s;
        first_flag_reg <= 1'b1;
      end
      if (state_reg == COLLECT && block_done) begin
        last_flag_reg <= in_last;
        core_m_reg    <= pk_m;
        core_fb_reg   <= pk_fb;
      end
      if (state_reg == WAIT && core_rdy) begin
        first_flag_reg <= 1'b0;
        if (last_flag_reg) begin
          tag_reg       <= core_p;
          tag_valid_reg <= 1'b1;
        end
      end
      if (state_reg == TAG && tag_ready) begin
        tag_valid_reg <= 1'b0;
      end
    end
  end

  assign core_r     = core_r_reg;
  assign core_s     = core_s_reg;
  assign core_m     = core_m_reg;
  assign core_fb    = core_fb_reg;
  assign core_first = first_flag_reg;
  assign tag_valid  = tag_valid_reg;
  assign tag        = tag_reg;
  assign busy       = (state_reg != IDLE);

endmodule
